// File: rtl/mem_port_arbiter.sv
// Shared single-port memory sequencer for the IF and MEM stages.
// Data has priority over fetch, with a starvation escape for IF.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam int CW = 4;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LOAD_CNT = CW'(MEM_LATENCY - 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t state_q;
  state_t state_d;

  logic          owner_d_q;
  logic          we_q;
  logic [CW-1:0] wait_q;
  logic [SW-1:0] starve_q;

  logic if_elig;
  logic d_elig;
  logic grant_d;
  logic grant_if;
  logic busy;
  logic done;

  assign if_elig  = if_req & ~if_valid;
  assign d_elig   = d_req & ~d_valid;
  assign grant_d  = d_elig & ~(if_elig & (starve_q == LIMIT));
  assign grant_if = if_elig & ~grant_d;

  assign busy = (state_q == ISSUE) | (state_q == WAIT);
  // The count spans the ISSUE cycle, so latency 1 completes out of ISSUE.
  assign done = busy & (wait_q == '0);

  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = d_req & ~d_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_d | grant_if) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = done ? IDLE : WAIT;
      end
      WAIT: begin
        if (done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_d_q <= 1'b0;
      we_q      <= 1'b0;
      wait_q    <= '0;
      starve_q  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      if (state_q == IDLE) begin
        if (grant_if || !if_req) begin
          starve_q <= '0;
        end else if (grant_d && starve_q != LIMIT) begin
          starve_q <= starve_q + 1'b1;
        end
        if (grant_d || grant_if) begin
          owner_d_q <= grant_d;
          we_q      <= grant_d & d_we;
          mem_en    <= 1'b1;
          mem_we    <= grant_d & d_we;
          mem_addr  <= grant_d ? d_addr : if_addr;
          mem_wdata <= grant_d ? d_wdata : '0;
          wait_q    <= LOAD_CNT;
        end
      end else if (done) begin
        if (owner_d_q) begin
          d_valid <= 1'b1;
          if (!we_q) begin
            d_rdata <= mem_rdata;
          end
        end else begin
          if_valid <= 1'b1;
          if_rdata <= mem_rdata;
        end
      end else if (busy) begin
        wait_q <= wait_q - 1'b1;
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Sequences a single-port unified instruction/data memory shared by the pipeline's IF stage (instruction fetch) and MEM stage (load/store). Arbitrates between the two requesters and drives the memory port through a fixed-latency access. Returns read data and a completion strobe to each requester. Exports stall signals to the pipeline control so that IF and MEM hold while their access is pending.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LATENCY, 2, cycles from mem_en to valid mem_rdata; legal range 1..15
STARVE_LIMIT, 4, consecutive data grants allowed while IF waits before IF is forced

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
if_req  input  1  fetch request; held until if_valid
if_addr  input  ADDR_W  fetch address
if_rdata  output  DATA_W  fetched instruction, valid when if_valid=1
if_valid  output  1  one-cycle fetch completion strobe
d_req  input  1  data request; held until d_valid
d_we  input  1  1 = store, 0 = load
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  store data
d_rdata  output  DATA_W  load data, valid when d_valid=1
d_valid  output  1  one-cycle data completion strobe (loads and stores)
mem_en  output  1  memory access strobe, exactly one cycle per access
mem_we  output  1  memory write enable, qualified by mem_en
mem_addr  output  ADDR_W  memory address, stable from mem_en until completion
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid MEM_LATENCY cycles after mem_en
stall_if  output  1  if_req & ~if_valid (combinational)
stall_mem  output  1  d_req & ~d_valid (combinational)

Behaviour:
- Reset (reset=0, asynchronous): FSM=IDLE. All registered outputs are 0: mem_en, mem_we, mem_addr, mem_wdata, if_valid, d_valid, if_rdata, d_rdata. Wait counter and starvation counter are 0. An in-flight access is discarded and no valid strobe is produced for it.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: arbitrate among eligible requests. A requester whose valid strobe is 1 in the current cycle is ineligible that cycle.
  - Data wins over IF, except when starve_cnt == STARVE_LIMIT; then IF wins.
  - On a grant, latch owner, address, we (forced to 0 for IF) and wdata, then go to ISSUE.
  - With no eligible request, stay in IDLE.
- ISSUE (1 cycle): mem_en=1 and mem_we=latched we. Load wait_cnt=MEM_LATENCY-1, then go to WAIT.
- WAIT: mem_en=0 and address/wdata are held.
  - If wait_cnt==0: register mem_rdata into the owner's rdata, pulse the owner's valid for the next cycle, and go to IDLE.
  - Otherwise decrement wait_cnt.
  - For stores, d_rdata is unchanged and d_valid still pulses.
- Latency: request seen in IDLE at cycle N gives mem_en at N+1 and valid at N+1+MEM_LATENCY. The valid cycle coincides with IDLE, so back-to-back accesses have 1 dead cycle; throughput is one access per MEM_LATENCY+2 cycles.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each data grant made while if_req=1.
  - Clears on an IF grant or whenever if_req=0 in IDLE.
- Inputs are sampled only at grant. Changes to addr/we/wdata while an access is in flight are ignored.
- Requester deasserts or changes req only after its valid strobe. A req that drops before its grant is simply not served.
- rdata outputs hold their last value until overwritten by the next completion for that port.

Test Plan:
- Reset mid-WAIT: load d_addr=0x14 issued, reset=0 during WAIT -> all outputs 0 immediately; no d_valid after release; FSM restarts in IDLE.
- Single fetch: if_req=1, if_addr=0x0, mem_rdata=0x20080005 -> mem_en pulses at cycle 1; if_valid=1 with if_rdata=0x20080005 at cycle 3; stall_if=1 during cycles 0..2.
- Store then load: d_req store d_addr=0x18, d_wdata=0xDEADBEEF, then load 0x18 -> mem_we=1 only on the store's mem_en; d_valid pulses twice; the load returns mem_rdata; exactly one dead cycle between accesses.
- Simultaneous requests: if_req and d_req raised together -> data is served first, IF second; stall_if stays high across both accesses.
- Starvation: if_req held, data requests continuous, STARVE_LIMIT=4 -> exactly 4 data grants, then the IF grant, then data resumes.
- Latency sweep: MEM_LATENCY=1 and 3 -> valid arrives exactly MEM_LATENCY+1 cycles after the grant cycle; mem_addr is stable throughout WAIT.
